// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and the receiver FSM state type.
// Holds the default frame geometry and the 50 MHz / 115200 baud dividers
// that the baud-rate generator also uses.
package uart_pkg;

  localparam int DATA_BITS_DEF   = 8;
  localparam int OVERSAMPLE_DEF  = 16;
  localparam int SYNC_STAGES_DEF = 2;

  localparam int CLK_HZ   = 50_000_000;
  localparam int BAUD     = 115_200;
  // Whole-bit divider (434) and the 16x oversample divider (27).
  localparam int BAUD_DIV    = CLK_HZ / BAUD;
  localparam int BAUD_DIV_OS = CLK_HZ / (BAUD * OVERSAMPLE_DEF);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_receiver_if.sv
// uart_receiver_if: serial input, oversample strobe and byte-ready handshake
// between the UART receiver (master) and its consumer (slave).
// parity_err exists only when UART_RX_PARITY_EN is defined.
interface uart_receiver_if #(
  parameter int DATA_BITS = 8
);

  logic                 rx;
  logic                 rxclk_en;
  logic                 rdy_clr;
  logic [DATA_BITS-1:0] data_out;
  logic                 rdy;
  logic                 frame_err;
  logic                 overrun_err;
  logic                 rx_busy;
`ifdef UART_RX_PARITY_EN
  logic                 parity_err;

  modport master (
    input  rx, rxclk_en, rdy_clr,
    output data_out, rdy, frame_err, overrun_err, rx_busy, parity_err
  );

  modport slave (
    output rx, rxclk_en, rdy_clr,
    input  data_out, rdy, frame_err, overrun_err, rx_busy, parity_err
  );
`else
  modport master (
    input  rx, rxclk_en, rdy_clr,
    output data_out, rdy, frame_err, overrun_err, rx_busy
  );

  modport slave (
    output rx, rxclk_en, rdy_clr,
    input  data_out, rdy, frame_err, overrun_err, rx_busy
  );
`endif

endinterface

// File: rtl/uart_sync.sv
// uart_sync: STAGES-deep flop chain for an asynchronous single-bit input.
// Presets to 1 on reset so an idle-high line never looks like activity.
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  // Shift the raw input one stage further along the chain each clock.
  always_comb begin
    // NOTE: every bit gets a default before any conditional or partial
    // assignment, so no path through the block can infer a latch.
    chain_d    = chain_q;
    chain_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      chain_d[i] = chain_q[i-1];
    end
  end

  // Chain registers with asynchronous preset to the idle level.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples its pre-edge inputs regardless of block ordering.
    if (rst) chain_q <= '1;
    else     chain_q <= chain_d;
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: UART receiver (8N1 by default) driven by a 16x oversample
// strobe. Bytes are presented on data_out with a sticky rdy flag and
// sticky frame/overrun error flags, all cleared by rdy_clr.
// Define UART_RX_PARITY_EN to add an even-parity bit and parity_err.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = DATA_BITS_DEF,
  parameter int OVERSAMPLE  = OVERSAMPLE_DEF,  // even, >= 4
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input logic             clk_50m,
  input logic             rst,
  uart_receiver_if.master bus
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  logic                 rx_s;

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 armed_q, armed_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 rdy_q, rdy_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_err_q, overrun_err_d;
`ifdef UART_RX_PARITY_EN
  logic                 parity_err_q, parity_err_d;
`endif

  uart_sync #(
    .STAGES (SYNC_STAGES)
  ) u_rx_sync (
    .clk (clk_50m),
    .rst (rst),
    .d   (bus.rx),
    .q   (rx_s)
  );

  // Frame FSM, sample counter and sticky output flags; clear first, then
  // any set from this cycle's sample wins over the clear.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_d         = bit_q;
    shift_d       = shift_q;
    armed_d       = armed_q;
    data_d        = data_q;
    rdy_d         = rdy_q;
    frame_err_d   = frame_err_q;
    overrun_err_d = overrun_err_q;
`ifdef UART_RX_PARITY_EN
    parity_err_d  = parity_err_q;
`endif

    if (bus.rdy_clr) begin
      rdy_d         = 1'b0;
      frame_err_d   = 1'b0;
      overrun_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_d  = 1'b0;
`endif
    end

    if (bus.rxclk_en) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;

      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          // Arming requires a high line first, so a held-low break after a
          // framing error cannot start a new frame.
          if (rx_s) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            state_d = START;
          end
        end

        START: begin
          if (cnt_q == CNT_MID) begin
            cnt_d = '0;
            if (!rx_s) begin
              state_d = DATA;
              bit_d   = '0;
            end else begin
              state_d = IDLE;  // line went back high: glitch, not a start bit
            end
          end
        end

        DATA: begin
          if (cnt_q == CNT_LAST) begin
            // LSB arrives first, so each new bit enters at the MSB end.
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_q == CNT_LAST) begin
            // Even parity: payload ones plus the parity bit must be even.
            if ((^shift_q) ^ rx_s) parity_err_d = 1'b1;
            state_d = STOP;
          end
        end
`endif

        STOP: begin
          if (cnt_q == CNT_LAST) begin
            if (rx_s) begin
              data_d = shift_q;
              rdy_d  = 1'b1;
              // An ack landing on the completion cycle consumed the old byte.
              if (rdy_q && !bus.rdy_clr) overrun_err_d = 1'b1;
            end else begin
              frame_err_d = 1'b1;
              armed_d     = 1'b0;
            end
            state_d = IDLE;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      armed_q       <= 1'b0;
      data_q        <= '0;
      rdy_q         <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      armed_q       <= armed_d;
      data_q        <= data_d;
      rdy_q         <= rdy_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
`ifdef UART_RX_PARITY_EN
      parity_err_q  <= parity_err_d;
`endif
    end
  end

  assign bus.data_out    = data_q;
  assign bus.rdy         = rdy_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.overrun_err = overrun_err_q;
  assign bus.rx_busy     = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err  = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed and randomized frames against a frame-level
// model of the receiver flags (byte delivered / framing error / overrun).
// Define UART_RX_PARITY_EN to also exercise the parity build.
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int OS = OVERSAMPLE_DEF;

  logic clk_50m = 1'b0;
  logic rst;
  int   tick_div = BAUD_DIV_OS;

  int n_checks = 0;
  int n_fail   = 0;

  // Frame-level reference state.
  logic [7:0] m_data;
  logic       m_rdy, m_ferr, m_oerr, m_perr;

  uart_receiver_if #(.DATA_BITS(8)) bus ();

  uart_receiver dut (
    .clk_50m (clk_50m),
    .rst     (rst),
    .bus     (bus)
  );

  always #10 clk_50m = ~clk_50m;

  // Oversample strobe: one clock high every tick_div clocks.
  initial begin
    bus.rxclk_en = 1'b0;
    forever begin
      repeat (tick_div - 1) @(negedge clk_50m);
      bus.rxclk_en = 1'b1;
      @(negedge clk_50m);
      bus.rxclk_en = 1'b0;
    end
  end

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_data = 8'h00; m_rdy = 1'b0; m_ferr = 1'b0; m_oerr = 1'b0; m_perr = 1'b0;
  endtask

  task automatic model_clear();
    m_rdy = 1'b0; m_ferr = 1'b0; m_oerr = 1'b0; m_perr = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] b, input logic stop_ok, input logic par);
`ifdef UART_RX_PARITY_EN
    if (((^b) ^ par) != 1'b0) m_perr = 1'b1;
`endif
    if (stop_ok) begin
      if (m_rdy) m_oerr = 1'b1;
      m_rdy  = 1'b1;
      m_data = b;
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".data"}, 32'(bus.data_out), 32'(m_data));
    check({tag, ".rdy"},  32'(bus.rdy), 32'(m_rdy));
    check({tag, ".ferr"}, 32'(bus.frame_err), 32'(m_ferr));
    check({tag, ".oerr"}, 32'(bus.overrun_err), 32'(m_oerr));
    check({tag, ".busy"}, 32'(bus.rx_busy), 32'd0);
`ifdef UART_RX_PARITY_EN
    check({tag, ".perr"}, 32'(bus.parity_err), 32'(m_perr));
`endif
  endtask

  // Wait for n strobes, then return on the following falling edge.
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk_50m); while (!bus.rxclk_en);
    end
    @(negedge clk_50m);
  endtask

  task automatic send_bit(input logic v);
    bus.rx = v;
    wait_ticks(OS);
  endtask

  task automatic send_start_data(input logic [7:0] b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par);
    send_start_data(b);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`endif
    send_bit(stop_v);
    bus.rx = 1'b1;
    wait_ticks(4);
  endtask

  task automatic pulse_clear();
    bus.rdy_clr = 1'b1;
    @(negedge clk_50m);
    bus.rdy_clr = 1'b0;
    model_clear();
  endtask

  initial begin
    int         ticks;
    int         cyc;
    logic       got;
    logic [7:0] b;
    logic       stop_ok;
    logic       par;

    rst         = 1'b1;
    bus.rx      = 1'b1;
    bus.rdy_clr = 1'b0;
    model_reset();
    repeat (5) @(negedge clk_50m);
    check_all("reset");
    rst = 1'b0;
    wait_ticks(2 * OS);

    // 1: single byte, latency into the stop bit, then ack.
    send_start_data(8'hA5);
`ifdef UART_RX_PARITY_EN
    send_bit(^8'hA5);
`endif
    bus.rx = 1'b1;
    check("t1.rdy_before_stop", 32'(bus.rdy), 32'd0);
    ticks = 0; cyc = 0; got = 1'b0;
    while (!got && cyc < 20 * tick_div) begin
      @(posedge clk_50m);
      if (bus.rxclk_en) ticks++;
      @(negedge clk_50m);
      cyc++;
      if (bus.rdy) got = 1'b1;
    end
    check("t1.rdy_seen", 32'(got), 32'd1);
    check("t1.mid_stop", 32'(ticks >= 7 && ticks <= 10), 32'd1);
    wait_ticks(12);
    model_frame(8'hA5, 1'b1, ^8'hA5);
    check_all("t1");
    pulse_clear();
    check("t1.cleared", 32'(bus.rdy), 32'd0);

    // 2: two bytes without ack -> overrun, newest byte kept.
    send_frame(8'h3C, 1'b1, ^8'h3C);
    model_frame(8'h3C, 1'b1, ^8'h3C);
    send_frame(8'hC3, 1'b1, ^8'hC3);
    model_frame(8'hC3, 1'b1, ^8'hC3);
    check_all("t2");
    pulse_clear();
    check_all("t2.clr");

    // 3: short low glitch is rejected at mid start bit.
    bus.rx = 1'b0;
    wait_ticks(4);
    check("t3.busy_in_glitch", 32'(bus.rx_busy), 32'd1);
    bus.rx = 1'b1;
    wait_ticks(16);
    check_all("t3");

    // 4: framing error, held-low break, recovery.
    send_start_data(8'h55);
`ifdef UART_RX_PARITY_EN
    send_bit(^8'h55);
`endif
    send_bit(1'b0);
    model_frame(8'h55, 1'b0, ^8'h55);
    check_all("t4.ferr");
    for (int f = 0; f < 3; f++) begin
      wait_ticks(10 * OS);
      check($sformatf("t4.break_idle%0d", f), 32'(bus.rx_busy), 32'd0);
    end
    check_all("t4.break");
    bus.rx = 1'b1;
    wait_ticks(2 * OS);
    send_frame(8'h12, 1'b1, ^8'h12);
    model_frame(8'h12, 1'b1, ^8'h12);
    check_all("t4.after");

    // 5: reset in bit 4 of 0xFF clears everything at once.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    bus.rx = 1'b1;
    wait_ticks(8);
    rst = 1'b1;
    #1;
    model_reset();
    check_all("t5.rst");
    @(negedge clk_50m);
    rst = 1'b0;
    wait_ticks(2 * OS);
    send_frame(8'h81, 1'b1, ^8'h81);
    model_frame(8'h81, 1'b1, ^8'h81);
    check_all("t5");

    // 7: ack held across completion -> set wins, no overrun.
    send_start_data(8'h99);
`ifdef UART_RX_PARITY_EN
    send_bit(^8'h99);
`endif
    bus.rx      = 1'b1;
    bus.rdy_clr = 1'b1;
    @(negedge clk_50m);
    check("t7.cleared", 32'(bus.rdy), 32'd0);
    cyc = 0; got = 1'b0;
    while (!got && cyc < 20 * tick_div) begin
      @(negedge clk_50m);
      cyc++;
      if (bus.rdy) got = 1'b1;
    end
    bus.rdy_clr = 1'b0;
    check("t7.rdy_seen", 32'(got), 32'd1);
    model_clear();
    model_frame(8'h99, 1'b1, ^8'h99);
    wait_ticks(12);
    check_all("t7");
    pulse_clear();

`ifdef UART_RX_PARITY_EN
    // 6: parity mismatch still delivers; correct parity leaves flag low.
    send_frame(8'h07, 1'b1, 1'b0);
    model_frame(8'h07, 1'b1, 1'b0);
    check_all("t6.bad");
    pulse_clear();
    send_frame(8'h07, 1'b1, 1'b1);
    model_frame(8'h07, 1'b1, 1'b1);
    check_all("t6.good");
    pulse_clear();
`endif

    // Randomized frames at a faster strobe rate.
    tick_div = 8;
    wait_ticks(2 * OS);
    for (int k = 0; k < 10; k++) begin
      b       = 8'($urandom_range(0, 255));
      stop_ok = ($urandom_range(0, 3) != 0);
      par     = (^b) ^ ($urandom_range(0, 3) == 0);
      send_frame(b, stop_ok, par);
      model_frame(b, stop_ok, par);
      check_all($sformatf("rand%0d", k));
      if ($urandom_range(0, 1) == 1) pulse_clear();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
